// File: rtl/sb_mem_slave_if.sv
// System bus link between a bus master and sb_mem_slave.
// master drives the *_i lines, slave drives the OR'd *_o lines.
interface sb_mem_slave_if;
  logic        sb_begin_transaction_i;
  logic [31:0] sb_address_data_i;
  logic [3:0]  sb_byte_enables_i;
  logic [7:0]  sb_burst_size_i;
  logic        sb_read_n_write_i;
  logic        sb_data_valid_i;
  logic        sb_end_transaction_i;
  logic        sb_error_i;
  logic [31:0] sb_address_data_o;
  logic        sb_data_valid_o;
  logic        sb_end_transaction_o;
  logic        sb_busy_o;
  logic        sb_error_o;

  modport master (
    output sb_begin_transaction_i,
    output sb_address_data_i,
    output sb_byte_enables_i,
    output sb_burst_size_i,
    output sb_read_n_write_i,
    output sb_data_valid_i,
    output sb_end_transaction_i,
    output sb_error_i,
    input  sb_address_data_o,
    input  sb_data_valid_o,
    input  sb_end_transaction_o,
    input  sb_busy_o,
    input  sb_error_o
  );

  modport slave (
    input  sb_begin_transaction_i,
    input  sb_address_data_i,
    input  sb_byte_enables_i,
    input  sb_burst_size_i,
    input  sb_read_n_write_i,
    input  sb_data_valid_i,
    input  sb_end_transaction_i,
    input  sb_error_i,
    output sb_address_data_o,
    output sb_data_valid_o,
    output sb_end_transaction_o,
    output sb_busy_o,
    output sb_error_o
  );
endinterface

// File: rtl/sb_mem_slave.sv
// Word-addressed scratch RAM slave on the system bus (burst rd/wr).
// Ports: sb_clock_i, sb_reset_i (sync, active-high), sb (slave modport).
// Option: define SB_MEM_SLAVE_STALL_EN for a gap after every 4th read beat.
module sb_mem_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 10,
  parameter int          READ_WAIT  = 2
) (
  input logic           sb_clock_i,
  input logic           sb_reset_i,
  sb_mem_slave_if.slave sb
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_RD_BURST = 3'd2;
  localparam logic [2:0] S_RD_END   = 3'd3;
  localparam logic [2:0] S_WR_BURST = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  localparam int          WORDS = 1 << ADDR_WIDTH;
  localparam logic [3:0]  RW    = READ_WAIT[3:0];
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]           mem [WORDS];
  logic [2:0]            state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [8:0]            cnt_q;
  logic [3:0]            wait_q;

  logic [31:0] addr;
  logic        hit;
  logic        aligned;
  logic        last_beat;
  logic        wr_beat;
  logic        gap;
  logic        rd_beat;

  assign addr      = sb.sb_address_data_i;
  assign hit       = sb.sb_begin_transaction_i &&
    (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign aligned   = (addr[1:0] == 2'b00);
  assign last_beat = (cnt_q == 9'd1);
  // Beats past the programmed length are dropped; error/reset kill the beat.
  assign wr_beat   = (state_q == S_WR_BURST) &&
                     sb.sb_data_valid_i && (cnt_q != 9'd0) &&
                     !sb.sb_error_i && !sb_reset_i;

`ifdef SB_MEM_SLAVE_STALL_EN
  logic       gap_q;
  logic [1:0] grp_q;

  assign gap = gap_q;

  // grp_q counts beats within a group of four; a gap follows
  // the 4th unless it was the final beat.
  always_ff @(posedge sb_clock_i) begin
    if (sb_reset_i || sb.sb_error_i ||
        state_q != S_RD_BURST) begin
      gap_q <= 1'b0;
      grp_q <= 2'd0;
    end else if (gap_q) begin
      gap_q <= 1'b0;
    end else begin
      grp_q <= grp_q + 2'd1;
      gap_q <= (grp_q == 2'd3) && !last_beat;
    end
  end
`else
  assign gap = 1'b0;
`endif

  always_ff @(posedge sb_clock_i) begin
    if (sb_reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else if (state_q != S_IDLE && sb.sb_error_i) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            idx_q  <= addr[ADDR_WIDTH+1:2];
            cnt_q  <= {1'b0, sb.sb_burst_size_i} + 9'd1;
            wait_q <= RW - 4'd1;
            if (!aligned)
              state_q <= S_ERR;
            else if (!sb.sb_read_n_write_i)
              state_q <= S_WR_BURST;
            else if (READ_WAIT == 0)
              state_q <= S_RD_BURST;
            else
              state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (wait_q == 4'd0)
            state_q <= S_RD_BURST;
          else
            wait_q <= wait_q - 4'd1;
        end
        S_RD_BURST: begin
          if (!gap) begin
            idx_q <= idx_q + IDX_ONE;
            cnt_q <= cnt_q - 9'd1;
            if (last_beat)
              state_q <= S_RD_END;
          end
        end
        S_WR_BURST: begin
          if (wr_beat) begin
            idx_q <= idx_q + IDX_ONE;
            cnt_q <= cnt_q - 9'd1;
          end
          if (sb.sb_end_transaction_i)
            state_q <= S_IDLE;
        end
        S_RD_END: state_q <= S_IDLE;
        S_ERR:    state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sb_clock_i) begin
    if (wr_beat) begin
      for (int b = 0; b < 4; b++) begin
        if (sb.sb_byte_enables_i[b])
          mem[idx_q][8*b +: 8] <= addr[8*b +: 8];
      end
    end
  end

  assign rd_beat = (state_q == S_RD_BURST) && !gap;

  assign sb.sb_address_data_o    = rd_beat ? mem[idx_q] : 32'h0;
  assign sb.sb_data_valid_o      = rd_beat;
  assign sb.sb_end_transaction_o = (state_q == S_RD_END) ||
                                   (state_q == S_ERR);
  assign sb.sb_busy_o            = (state_q == S_RD_WAIT) ||
                                   (state_q == S_RD_BURST && gap);
  assign sb.sb_error_o           = (state_q == S_ERR);

endmodule

// File: tb/tb_sb_mem_slave.sv
// Bench for sb_mem_slave: directed + random bursts vs a word-array model.
// Expected output streams are built from the bus timing rules per transaction.
module tb_sb_mem_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          AW    = 10;
  localparam int          RW    = 2;
  localparam int          WORDS = 1 << AW;
`ifdef SB_MEM_SLAVE_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic        busy;
    logic        endt;
    logic        dv;
    logic [31:0] data;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sb_mem_slave_if bus ();

  sb_mem_slave #(
    .BASE_ADDR (BASE),
    .ADDR_WIDTH(AW),
    .READ_WAIT (RW)
  ) dut (
    .sb_clock_i(clk),
    .sb_reset_i(rst),
    .sb        (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [WORDS];
  logic [31:0] wd [$];
  logic [3:0]  wb [$];

  function automatic obs_t cur();
    obs_t o;
    o.err  = bus.sb_error_o;
    o.busy = bus.sb_busy_o;
    o.endt = bus.sb_end_transaction_o;
    o.dv   = bus.sb_data_valid_o;
    o.data = bus.sb_address_data_o;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t exp);
    obs_t o;
    o = cur();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, o, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.sb_begin_transaction_i = 1'b0;
    bus.sb_address_data_i      = 32'h0;
    bus.sb_byte_enables_i      = 4'h0;
    bus.sb_burst_size_i        = 8'h0;
    bus.sb_read_n_write_i      = 1'b0;
    bus.sb_data_valid_i        = 1'b0;
    bus.sb_end_transaction_i   = 1'b0;
    bus.sb_error_i             = 1'b0;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a[31:AW+2] == BASE[31:AW+2];
  endfunction

  // abort_at: cycle after begin where reset (abort_rst) or bus error hits.
  task automatic run_read(input logic [31:0] addr, input int bsz,
                          input int abort_at, input bit abort_rst,
                          input bit noise);
    obs_t q[$];
    obs_t e;
    obs_t z;
    int   n;
    int   base_i;
    z = '0;
    n = bsz + 1;
    base_i = int'(addr[AW+1:2]);
    if (in_win(addr)) begin
      if (addr[1:0] != 2'b00) begin
        e = '0; e.err = 1'b1; e.endt = 1'b1;
        q.push_back(e);
      end else begin
        for (int i = 0; i < RW; i++) begin
          e = '0; e.busy = 1'b1;
          q.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
          e = '0; e.dv = 1'b1;
          e.data = model[(base_i + k) % WORDS];
          q.push_back(e);
          if (STALL && (k % 4 == 3) && (k != n - 1)) begin
            e = '0; e.busy = 1'b1;
            q.push_back(e);
          end
        end
        e = '0; e.endt = 1'b1;
        q.push_back(e);
      end
    end
    bus.sb_begin_transaction_i = 1'b1;
    bus.sb_address_data_i      = addr;
    bus.sb_burst_size_i        = 8'(bsz);
    bus.sb_read_n_write_i      = 1'b1;
    chk("rd_begin", z);
    tick();
    bus_idle();
    for (int c = 1; c <= q.size(); c++) begin
      if (noise && c == 1) begin
        bus.sb_begin_transaction_i = 1'b1;
        bus.sb_address_data_i      = BASE;
        bus.sb_read_n_write_i      = 1'b0;
      end
      if (c == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else bus.sb_error_i = 1'b1;
      end
      chk($sformatf("rd_cyc%0d", c), q[c-1]);
      tick();
      bus_idle();
      rst = 1'b0;
      if (c == abort_at) break;
    end
    chk("rd_after", z);
    tick();
    chk("rd_after2", z);
  endtask

  // Beats come from wd/wb; err_beat >= 0 raises sb_error_i on that beat.
  task automatic run_write(input logic [31:0] addr, input int bsz,
                           input int err_beat);
    obs_t z;
    int   base_i;
    int   nb;
    int   w;
    z = '0;
    base_i = int'(addr[AW+1:2]);
    nb = wd.size();
    bus.sb_begin_transaction_i = 1'b1;
    bus.sb_address_data_i      = addr;
    bus.sb_burst_size_i        = 8'(bsz);
    bus.sb_read_n_write_i      = 1'b0;
    chk("wr_begin", z);
    tick();
    bus_idle();
    for (int i = 0; i < nb; i++) begin
      bus.sb_data_valid_i      = 1'b1;
      bus.sb_address_data_i    = wd[i];
      bus.sb_byte_enables_i    = wb[i];
      bus.sb_end_transaction_i = (i == nb - 1);
      bus.sb_error_i           = (i == err_beat);
      if (i != err_beat && i <= bsz) begin
        w = (base_i + i) % WORDS;
        for (int b = 0; b < 4; b++)
          if (wb[i][b]) model[w][8*b +: 8] = wd[i][8*b +: 8];
      end
      chk($sformatf("wr_beat%0d", i), z);
      tick();
      bus_idle();
      if (i == err_beat) break;
    end
    chk("wr_after", z);
    wd.delete();
    wb.delete();
  endtask

  initial begin
    obs_t z;
    z = '0;
    rst = 1'b1;
    bus_idle();
    tick();
    tick();
    chk("reset_state", z);
    rst = 1'b0;
    tick();
    chk("post_reset", z);

    // Fill the whole window so every later read has a known model value.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wd.push_back($urandom);
        wb.push_back(4'hF);
      end
      run_write(BASE + 32'(blk * 1024), 255, -1);
    end

    wd.push_back(32'hDEAD_BEEF); wb.push_back(4'hF);
    run_write(BASE, 0, -1);
    run_read(BASE, 0, -1, 1'b0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      wd.push_back(32'(i)); wb.push_back(4'hF);
    end
    run_write(BASE + 32'h20, 3, -1);
    run_read(BASE + 32'h20, 3, -1, 1'b0, 1'b0);

    wd.push_back(32'h1122_3344); wb.push_back(4'hF);
    run_write(BASE + 32'h40, 0, -1);
    wd.push_back(32'hAABB_CCDD); wb.push_back(4'b0101);
    run_write(BASE + 32'h40, 0, -1);
    run_read(BASE + 32'h40, 0, -1, 1'b0, 1'b0);

    run_read(BASE + 32'hFFC, 1, -1, 1'b0, 1'b0);

    run_read(BASE + 32'h2, 0, -1, 1'b0, 1'b0);
    run_read(BASE + 32'h4, 0, -1, 1'b0, 1'b0);

    run_read(BASE + 32'h100, 7, RW + 2, 1'b1, 1'b0);
    run_read(BASE + 32'h100, 7, -1, 1'b0, 1'b0);

    run_read(BASE + 32'h200, 7, RW + 3, 1'b0, 1'b0);
    run_read(BASE + 32'h200, 2, -1, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      wd.push_back($urandom); wb.push_back(4'hF);
    end
    run_write(BASE + 32'h300, 3, 2);
    run_read(BASE + 32'h300, 3, -1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      wd.push_back($urandom); wb.push_back(4'hF);
    end
    run_write(BASE + 32'h3F8, 1, -1);
    run_read(BASE + 32'h3F8, 2, -1, 1'b0, 1'b0);

    run_read(32'h0000_0FFC, 0, -1, 1'b0, 1'b0);
    run_read(32'h0000_2000, 3, -1, 1'b0, 1'b0);

    run_read(BASE + 32'h800, 255, -1, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      int          bsz;
      int          nb;
      a   = BASE + ($urandom_range(0, WORDS - 1) << 2);
      bsz = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        nb = bsz + 1 + $urandom_range(0, 2) - 1;
        if (nb < 1) nb = 1;
        for (int i = 0; i < nb; i++) begin
          wd.push_back($urandom);
          wb.push_back(4'($urandom_range(0, 15)));
        end
        run_write(a, bsz, -1);
      end else begin
        run_read(a, bsz, -1, 1'b0, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
